// File: rtl/pulse_cdc_pkg.sv
// Shared types and defaults for the pulse CDC scheduler: FSM state encoding,
// default timing constants and a small modular-increment helper.
package pulse_cdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_CNT_W       = 3;
    localparam int DEF_GAP_CYC     = 2;
    localparam int DEF_TIMEOUT_CYC = 64;

    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/pulse_pend_cnt.sv
// Per-requester pending-event counter: saturating up/down count with a sticky
// overflow flag for events that arrive while the counter is already full.
module pulse_pend_cnt
    import pulse_cdc_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_100mhz,
    input  logic             rstn,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;

    // Simultaneous inc and dec cancel; a lone inc at full scale is the only
    // way an event can be lost, so that is exactly when the flag is raised.
    // The set is applied after the clear so it wins a same-cycle collision.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (inc && !dec) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);
    assign ovf     = ovf_q;

endmodule

// File: rtl/pulse_cdc_scheduler.sv
// Shares one fast-to-slow pulse synchronizer among N_REQ requesters: queues
// events per requester, grants round-robin and paces issues on the returned ack.
module pulse_cdc_scheduler
    import pulse_cdc_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk_100mhz,
    input  logic             rstn,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             ack_in,
    input  logic             clr_err,
    output logic             pulse_out,
    output logic [ID_W-1:0]  chan_id,
    output logic             busy,
    output logic [N_REQ-1:0] ovf_flag,
    output logic             timeout_err
);

    localparam int             TO_W     = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]     GAP_LAST = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;
    localparam state_t         AFTER_WAIT = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;

    state_t           state_q;
    state_t           state_d;
    logic [ID_W-1:0]  chan_id_q;
    logic [ID_W-1:0]  chan_id_d;
    logic [ID_W-1:0]  rr_q;
    logic [ID_W-1:0]  rr_d;
    logic [TO_W-1:0]  tcnt_q;
    logic [TO_W-1:0]  tcnt_d;
    logic [3:0]       gcnt_q;
    logic [3:0]       gcnt_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             terr_q;
    logic             terr_d;

    logic [N_REQ-1:0] cnt_nz;
    logic [N_REQ-1:0] grant;
    logic             grant_en;
    logic             timeout_evt;
    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic [ID_W-1:0]  cand;
    logic [CNT_W-1:0] pend_cnt_unused [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_pend
            assign grant[gi] = grant_en && (pick_idx == ID_W'(gi));

            pulse_pend_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk_100mhz (clk_100mhz),
                .rstn       (rstn),
                .inc        (req_pulse[gi]),
                .dec        (grant[gi]),
                .clr_ovf    (clr_err),
                .count      (pend_cnt_unused[gi]),
                .nonzero    (cnt_nz[gi]),
                .ovf        (ovf_flag[gi])
            );
        end
    endgenerate

    // Round-robin search starting at the pointer; it only sees registered
    // counts, so a pulse arriving this cycle competes from the next cycle on.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(rr_q) + k) % N_REQ);
            if (!pick_found && cnt_nz[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        chan_id_d   = chan_id_q;
        rr_d        = rr_q;
        tcnt_d      = tcnt_q;
        gcnt_d      = gcnt_q;
        pulse_d     = 1'b0;
        grant_en    = 1'b0;
        timeout_evt = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_en  = 1'b1;
                    chan_id_d = pick_idx;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pulse_d = 1'b1;
                rr_d    = ID_W'(wrap_inc(int'(chan_id_q), N_REQ));
                tcnt_d  = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // Ack is checked first so it beats a coincident timeout.
                if (ack_in) begin
                    gcnt_d  = '0;
                    state_d = AFTER_WAIT;
                end else if (tcnt_q == TO_LAST) begin
                    timeout_evt = 1'b1;
                    gcnt_d      = '0;
                    state_d     = AFTER_WAIT;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        terr_d = terr_q;
        if (clr_err) begin
            terr_d = 1'b0;
        end
        if (timeout_evt) begin
            terr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            chan_id_q <= '0;
            rr_q      <= '0;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
            pulse_q   <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_id_q <= chan_id_d;
            rr_q      <= rr_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
            pulse_q   <= pulse_d;
            terr_q    <= terr_d;
        end
    end

    // pulse_out comes straight from a flop so the synchronizer sees a clean level.
    assign pulse_out   = pulse_q;
    assign chan_id     = chan_id_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_pulse_cdc_scheduler.sv
// Directed bench for pulse_cdc_scheduler: an event-time model of the scheduler
// is compared every cycle, plus literal expectations for the key scenarios.
module tb_pulse_cdc_scheduler;

    localparam int N    = 4;
    localparam int CW   = 3;
    localparam int G    = 2;
    localparam int T    = 64;
    localparam int MAXC = 7;
    localparam int D    = 3;
    localparam int BIG  = 1 << 30;

    logic           clk_100mhz = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_pulse;
    logic           ack_in;
    logic           clr_err;
    logic           pulse_out;
    logic [1:0]     chan_id;
    logic           busy;
    logic [N-1:0]   ovf_flag;
    logic           timeout_err;

    pulse_cdc_scheduler #(
        .N_REQ       (N),
        .CNT_W       (CW),
        .GAP_CYC     (G),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .rstn        (rstn),
        .req_pulse   (req_pulse),
        .ack_in      (ack_in),
        .clr_err     (clr_err),
        .pulse_out   (pulse_out),
        .chan_id     (chan_id),
        .busy        (busy),
        .ovf_flag    (ovf_flag),
        .timeout_err (timeout_err)
    );

    initial forever #5 clk_100mhz = ~clk_100mhz;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: pending counts plus the timeline of the issue in flight.
    int           m_cnt [N];
    logic [N-1:0] m_ovf;
    logic         m_terr;
    int           m_rr;
    bit           m_act;
    int           m_ch, m_p, m_dl, m_bs, m_be, m_idle;

    // Ack responder and DUT pulse log.
    bit ack_en     = 1'b1;
    bit drop_next  = 1'b0;
    bit manual_ack = 1'b0;
    bit pend       = 1'b0;
    int due        = 0;
    int pulses     = 0;
    int order_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ovf  = '0;
        m_terr = 1'b0;
        m_rr   = 0;
        m_act  = 1'b0;
        m_ch   = 0;
        m_p    = -1;
        m_dl   = -1;
        m_bs   = -1;
        m_be   = -1;
        m_idle = 0;
    endtask

    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            if (m_cnt[(m_rr + k) % N] != 0) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // Applies the inputs of cycle e and advances the model to cycle e+1.
    task automatic model_edge(input int e);
        logic [N-1:0] dec;
        logic [N-1:0] oset;
        bit           tset;
        int           pk;
        if (!rstn) begin
            model_reset();
            return;
        end
        dec  = '0;
        oset = '0;
        tset = 1'b0;
        if (m_act && e >= m_p) begin
            if (ack_in) begin
                m_act = 1'b0; m_idle = e + G + 1; m_be = m_idle;
            end else if (e == m_dl) begin
                m_act = 1'b0; tset = 1'b1; m_idle = e + G + 1; m_be = m_idle;
            end
        end
        if (!m_act && e >= m_idle) begin
            pk = model_pick();
            if (pk >= 0) begin
                m_act = 1'b1;
                m_ch  = pk;
                m_rr  = (pk + 1) % N;
                m_p   = e + 2;
                m_dl  = e + 2 + T - 1;
                m_bs  = e + 1;
                m_be  = BIG;
                m_cnt[pk]--;
                dec[pk] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_pulse[i]) begin
                if (m_cnt[i] == MAXC && !dec[i]) oset[i] = 1'b1;
                else m_cnt[i]++;
            end
        end
        if (clr_err) begin
            m_ovf  = '0;
            m_terr = 1'b0;
        end
        m_ovf = m_ovf | oset;
        if (tset) m_terr = 1'b1;
    endtask

    task automatic compare(input int n);
        bit exp_busy;
        if (!rstn) begin
            chk("rst_pulse_out", int'(pulse_out), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_ovf_flag", int'(ovf_flag), 0);
            chk("rst_timeout_err", int'(timeout_err), 0);
            chk("rst_chan_id", int'(chan_id), 0);
        end else begin
            exp_busy = (n >= m_bs) && (n < m_be);
            chk("pulse_out", int'(pulse_out), int'(n == m_p));
            chk("busy", int'(busy), int'(exp_busy));
            if (exp_busy) chk("chan_id", int'(chan_id), m_ch);
            chk("ovf_flag", int'(ovf_flag), int'(m_ovf));
            chk("timeout_err", int'(timeout_err), int'(m_terr));
        end
    endtask

    // One clock: model on the rising edge, compare and ack drive on the falling edge.
    task automatic tick();
        bit fire;
        @(posedge clk_100mhz);
        model_edge(cyc);
        cyc++;
        @(negedge clk_100mhz);
        compare(cyc);
        if (rstn && pulse_out) begin
            pulses++;
            order_q.push_back(int'(chan_id));
            if (!drop_next) begin
                pend = 1'b1;
                due  = cyc + D;
            end
        end
        if (!rstn) pend = 1'b0;
        fire = ack_en && pend && (cyc >= due);
        if (fire) pend = 1'b0;
        ack_in = fire || manual_ack;
    endtask

    task automatic wait_quiet(input string nm);
        int quiet = 0;
        for (int i = 0; i < 2000 && quiet < 3; i++) begin
            tick();
            quiet = (busy || pend) ? 0 : quiet + 1;
        end
        chk(nm, int'(quiet >= 3), 1);
    endtask

    initial begin
        int base, c0, ob;
        rstn = 1'b0; req_pulse = '0; ack_in = 1'b0; clr_err = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_pulse_out", int'(pulse_out), 0);
        chk("reset_ovf_flag", int'(ovf_flag), 0);
        chk("reset_timeout_err", int'(timeout_err), 0);
        rstn = 1'b1;
        repeat (2) tick();

        // Single event on requester 2: three-cycle latency, gap after ack.
        base = pulses; c0 = cyc;
        req_pulse = 4'b0100; tick(); req_pulse = '0; tick();
        chk("t1_no_early_pulse", int'(pulse_out), 0);
        tick();
        chk("t1_pulse_at_c3", int'(pulse_out), 1);
        chk("t1_chan_id", int'(chan_id), 2);
        repeat (5) tick();
        chk("t1_busy_during_gap", int'(busy), 1);
        tick();
        chk("t1_busy_drops", int'(busy), 0);
        wait_quiet("t1_drain");
        chk("t1_pulse_count", pulses - base, 1);

        // Seven back-to-back events on requester 0: all delivered, no overflow.
        base = pulses;
        for (int i = 0; i < 7; i++) begin
            req_pulse = 4'b0001; tick();
        end
        req_pulse = '0;
        wait_quiet("t2_drain");
        chk("t2_pulse_count", pulses - base, 7);
        chk("t2_no_ovf", int'(ovf_flag[0]), 0);

        // Round-robin from pointer 0, late requester 0 waits its turn.
        rstn = 1'b0; tick(); tick(); rstn = 1'b1; tick();
        ob = order_q.size();
        req_pulse = 4'b1111; tick(); req_pulse = '0;
        repeat (3) tick();
        req_pulse = 4'b0001; tick(); req_pulse = '0;
        wait_quiet("t3_drain");
        chk("t3_order_len", order_q.size() - ob, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t3_order_%0d", i), order_q[ob + i], i % 4);

        // Nine events on requester 1 with acks stalled: one lost, flag sticks.
        base = pulses; ack_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            req_pulse = 4'b0010; tick();
        end
        req_pulse = '0;
        repeat (4) tick();
        chk("t4_ovf_set", int'(ovf_flag[1]), 1);
        chk("t4_one_in_flight", pulses - base, 1);
        ack_en = 1'b1;
        wait_quiet("t4_drain");
        chk("t4_pulse_count", pulses - base, 8);
        chk("t4_no_timeout", int'(timeout_err), 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0; tick();
        chk("t4_ovf_cleared", int'(ovf_flag), 0);

        // Dropped ack on requester 3 times out; pending requester 0 follows.
        base = pulses; ob = order_q.size(); drop_next = 1'b1; c0 = cyc;
        req_pulse = 4'b1000; tick(); req_pulse = 4'b0001; tick(); req_pulse = '0; tick();
        chk("t5_pulse", int'(pulse_out), 1);
        chk("t5_chan_id", int'(chan_id), 3);
        drop_next = 1'b0;
        for (int i = 0; i < 200 && cyc < c0 + 3 + T - 1; i++) tick();
        chk("t5_no_err_yet", int'(timeout_err), 0);
        tick();
        chk("t5_timeout_err", int'(timeout_err), 1);
        wait_quiet("t5_drain");
        chk("t5_pulse_count", pulses - base, 2);
        chk("t5_next_served", order_q[ob + 1], 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("t5_err_cleared", int'(timeout_err), 0);

        // Reset in WAIT_ACK with three pending; a late ack must not re-issue.
        base = pulses; ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_pulse = 4'b0100; tick();
        end
        req_pulse = '0;
        repeat (4) tick();
        chk("t6_busy_before_rst", int'(busy), 1);
        rstn = 1'b0; #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_pulse_out", int'(pulse_out), 0);
        chk("t6_rst_chan_id", int'(chan_id), 0);
        tick(); tick();
        rstn = 1'b1; ack_en = 1'b1; tick();
        manual_ack = 1'b1; tick(); manual_ack = 1'b0;
        repeat (10) tick();
        chk("t6_no_new_pulse", pulses - base, 1);
        chk("t6_idle_after", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
